// File: rtl/mux_registrado.sv
`timescale 1ns/1ps
// mux_registrado
//   N-input multiplexer with a registered output stage and valid/ready
//   handshakes. It sits between several producers and one consumer and can
//   move one word per cycle. A channel is chosen either by `chave` (fixed
//   mode) or by round-robin arbitration.
//
// Configuration macro: MUX_RR_EN
//   Defined   : round-robin arbiter, pointer register and the `modo` port exist.
//   Undefined : fixed selection only; no `modo` port and no pointer register.
//
// Parameters
//   LARGURA : data width per channel (>= 1)
//   CANAIS  : number of input channels (>= 2)
//   SEL_W   : width of chave/canal_saida, always $clog2(CANAIS)
//
// Ports
//   clock        : rising-edge clock
//   reset_n      : asynchronous active-low reset
//   entradas     : packed channel data, channel i = entradas[i*LARGURA +: LARGURA]
//   validos      : per-channel valid
//   prontos      : per-channel ready, one-hot or zero
//   chave        : channel select used in fixed mode
//   modo         : 0 = fixed, 1 = round-robin (MUX_RR_EN only)
//   saida        : registered output data
//   saida_valida : output valid; this is also the state of the output FSM
//                  (0 = VAZIO, 1 = CHEIO)
//   saida_pronta : consumer ready
//   canal_saida  : index of the channel that produced saida
//
// Handshake rule, for both sides: a word moves on a rising edge where valid
// and ready are both 1. A producer is offered ready only when it holds the
// grant and the output register can take a word on this edge.
module mux_registrado #(
  parameter  int LARGURA = 16,
  parameter  int CANAIS  = 4,
  localparam int SEL_W   = $clog2(CANAIS)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CANAIS*LARGURA-1:0] entradas,
  input  logic [CANAIS-1:0]         validos,
  output logic [CANAIS-1:0]         prontos,
  input  logic [SEL_W-1:0]          chave,
`ifdef MUX_RR_EN
  input  logic                      modo,
`endif
  output logic [LARGURA-1:0]        saida,
  output logic                      saida_valida,
  input  logic                      saida_pronta,
  output logic [SEL_W-1:0]          canal_saida
);

  typedef enum logic {
    VAZIO = 1'b0,
    CHEIO = 1'b1
  } estado_t;

  estado_t            estado_q;
  logic [LARGURA-1:0] saida_q;
  logic [LARGURA-1:0] saida_d;
  logic [SEL_W-1:0]   canal_q;
  logic [SEL_W-1:0]   canal_d;

  logic               carga;
  logic               xfer;
  logic               tem_g;
  logic [SEL_W-1:0]   g;
  logic               fix_tem;
  logic [SEL_W-1:0]   fix_g;

  // The register can accept a word when empty, or when the consumer drains
  // the current word on this same edge (no bubble between words).
  assign carga = (estado_q == VAZIO) | saida_pronta;
  assign xfer  = tem_g & carga;

  // Fixed selection. Comparing against every legal index means a chave
  // value at or above CANAIS simply matches nothing and gives no grant.
  always_comb begin
    fix_tem = 1'b0;
    fix_g   = '0;
    for (int i = 0; i < CANAIS; i++) begin
      if (validos[i] && (int'(chave) == i)) begin
        fix_tem = 1'b1;
        fix_g   = SEL_W'(i);
      end
    end
  end

`ifdef MUX_RR_EN
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic             rr_tem;
  logic [SEL_W-1:0] rr_g;

  // Round-robin: scan starting one past the last granted channel, wrapping
  // modulo CANAIS; the first valid channel found wins.
  always_comb begin
    rr_tem = 1'b0;
    rr_g   = '0;
    for (int k = 1; k <= CANAIS; k++) begin
      for (int i = 0; i < CANAIS; i++) begin
        if (!rr_tem && validos[i] && (i == ((int'(ptr_q) + k) % CANAIS))) begin
          rr_tem = 1'b1;
          rr_g   = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    tem_g = fix_tem;
    g     = fix_g;
    if (modo) begin
      tem_g = rr_tem;
      g     = rr_g;
    end
  end

  // The pointer moves only when a word is actually taken from a channel.
  assign ptr_d = xfer ? g : ptr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= SEL_W'(CANAIS - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign tem_g = fix_tem;
  assign g     = fix_g;
`endif

  // Data of the granted channel.
  always_comb begin
    saida_d = '0;
    for (int i = 0; i < CANAIS; i++) begin
      if (g == SEL_W'(i)) begin
        saida_d = entradas[i*LARGURA +: LARGURA];
      end
    end
    canal_d = g;
  end

  // Ready goes only to the granted channel. It is held low during reset so
  // no producer sees a transfer that the register would discard.
  always_comb begin
    prontos = '0;
    for (int i = 0; i < CANAIS; i++) begin
      prontos[i] = reset_n & xfer & (g == SEL_W'(i));
    end
  end

  // Output register FSM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= VAZIO;
      saida_q  <= '0;
      canal_q  <= '0;
    end else begin
      case (estado_q)
        VAZIO: begin
          if (xfer) begin
            saida_q  <= saida_d;
            canal_q  <= canal_d;
            estado_q <= CHEIO;
          end
        end
        CHEIO: begin
          if (xfer) begin
            // Drain and reload on the same edge.
            saida_q  <= saida_d;
            canal_q  <= canal_d;
            estado_q <= CHEIO;
          end else if (saida_pronta) begin
            // Drained with nothing to replace it: data and channel hold.
            estado_q <= VAZIO;
          end
        end
      endcase
    end
  end

  assign saida        = saida_q;
  assign saida_valida = (estado_q == CHEIO);
  assign canal_saida  = canal_q;

endmodule
